// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for uart_rx: acknowledges bytes, packs them little-endian
// into 32-bit words and queues those words for a downstream memory writer.
//
// state    | meaning
// IDLE     | receiver disabled, nothing captured
// ARMED    | waiting for a byte; idle-line timer runs while a word is partial
// WAIT_CLR | byte acknowledged, waiting for rx_data_valid to drop
// FLUSH    | pushing a partial word (idle timeout or enable dropped)
module uart_rx_ctrl #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int BODE_RATE     = 115_200,
  parameter int TIMEOUT_CHARS = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        rx_data_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [1:0]  rx_ctrl,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [3:0]  word_strb,
  input  logic        word_ready,
  output logic        timeout,
  output logic [15:0] byte_count,
  output logic        busy
);

  localparam longint TIMEOUT_L =
    (longint'(TIMEOUT_CHARS) * longint'(10) * longint'(CLK_FREQ)) / longint'(BODE_RATE);
  localparam int TIMEOUT_CYCLES = int'(TIMEOUT_L);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ARMED, WAIT_CLR, FLUSH} state_t;

  state_t            state;
  logic [1:0]        byte_idx;
  logic [31:0]       lanes;
  logic [TMR_W-1:0]  tmr;
  logic              en_q;
  logic              ack;
  logic              flush_to;

  logic [31:0]       mem_data [FIFO_DEPTH];
  logic [3:0]        mem_strb [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;

  logic              pop;
  logic              push_ok;
  logic              capture;
  logic              push;
  logic [31:0]       push_data;
  logic [3:0]        push_strb;
  logic [3:0]        partial_strb;

  // rx_ready is status only; nothing in the sequencing depends on it.
  logic unused_rx_ready;
  assign unused_rx_ready = rx_ready;

  assign rx_ctrl    = {ack, en_q};
  assign word_valid = (fifo_count != '0);
  assign word_data  = mem_data[rd_ptr];
  assign word_strb  = mem_strb[rd_ptr];
  assign busy       = (byte_idx != 2'd0) || (fifo_count != '0);

  assign pop     = word_valid && word_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = (fifo_count < CNT_W'(FIFO_DEPTH)) || pop;
  assign capture = (state == ARMED) && enable && rx_data_valid &&
                   ((byte_idx != 2'd3) || push_ok);

  always_comb begin
    case (byte_idx)
      2'd1:    partial_strb = 4'b0001;
      2'd2:    partial_strb = 4'b0011;
      2'd3:    partial_strb = 4'b0111;
      default: partial_strb = 4'b0000;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    push_strb = '0;
    if (capture && (byte_idx == 2'd3)) begin
      push      = 1'b1;
      push_data = {rx_data, lanes[23:0]};
      push_strb = 4'b1111;
    end else if ((state == FLUSH) && push_ok) begin
      push      = 1'b1;
      push_data = lanes;
      push_strb = partial_strb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_strb[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_strb[wr_ptr] <= push_strb;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_idx   <= 2'd0;
      lanes      <= '0;
      tmr        <= '0;
      en_q       <= 1'b0;
      ack        <= 1'b0;
      flush_to   <= 1'b0;
      timeout    <= 1'b0;
      byte_count <= '0;
    end else begin
      en_q    <= enable;
      ack     <= capture;
      timeout <= 1'b0;

      if (capture) begin
        byte_count <= byte_count + 16'd1;
        tmr        <= TMR_W'(TIMEOUT_CYCLES - 1);
        if (byte_idx == 2'd3) begin
          byte_idx <= 2'd0;
          lanes    <= '0;
        end else begin
          lanes[{byte_idx, 3'b000} +: 8] <= rx_data;
          byte_idx <= byte_idx + 2'd1;
        end
      end

      case (state)
        IDLE: if (enable) state <= ARMED;
        ARMED: begin
          if (!enable) begin
            state    <= (byte_idx != 2'd0) ? FLUSH : IDLE;
            flush_to <= 1'b0;
          end else if (capture) begin
            state <= WAIT_CLR;
          end else if (byte_idx != 2'd0) begin
            if (tmr == '0) begin
              state    <= FLUSH;
              flush_to <= 1'b1;
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
        end
        WAIT_CLR: begin
          if (!enable) begin
            state    <= (byte_idx != 2'd0) ? FLUSH : IDLE;
            flush_to <= 1'b0;
          end else if (!rx_data_valid) begin
            state <= ARMED;
          end
        end
        FLUSH: begin
          if (push_ok) begin
            timeout  <= flush_to;
            byte_idx <= 2'd0;
            lanes    <= '0;
            state    <= enable ? ARMED : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomised bench for uart_rx_ctrl: a uart_rx byte source, a word-stream
// reference model built from the byte sequence, and a scoreboard on the word port.
module tb_uart_rx_ctrl;

  localparam int CLK_FREQ      = 100_000_000;
  localparam int BODE_RATE     = 10_000_000;
  localparam int TIMEOUT_CHARS = 4;
  localparam int FIFO_DEPTH    = 4;
  localparam int TO_CYC =
    int'((longint'(TIMEOUT_CHARS) * longint'(10) * longint'(CLK_FREQ)) / longint'(BODE_RATE));

  logic        clk;
  logic        rst;
  logic        enable;
  logic        rx_data_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [1:0]  rx_ctrl;
  logic        word_valid;
  logic [31:0] word_data;
  logic [3:0]  word_strb;
  logic        word_ready;
  logic        timeout;
  logic [15:0] byte_count;
  logic        busy;

  uart_rx_ctrl #(
    .CLK_FREQ(CLK_FREQ),
    .BODE_RATE(BODE_RATE),
    .TIMEOUT_CHARS(TIMEOUT_CHARS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .rx_data_valid(rx_data_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .rx_ctrl(rx_ctrl),
    .word_valid(word_valid),
    .word_data(word_data),
    .word_strb(word_strb),
    .word_ready(word_ready),
    .timeout(timeout),
    .byte_count(byte_count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
  } word_t;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ack_cnt = 0;
  int          to_cnt = 0;
  int          last_ack_cyc = 0;
  int          last_to_cyc = 0;
  int          max_gap = 2;
  int          ready_mode = 0;  // 0 low, 1 high, 2 random
  int          m_bc = 0;
  logic [7:0]  tx_q [$];
  logic [7:0]  m_acc [$];
  word_t       exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bytes become words four at a time, little-endian.
  task automatic m_emit();
    word_t w;
    w.d = '0;
    for (int i = 0; i < m_acc.size(); i++) w.d = w.d | (32'(m_acc[i]) << (8 * i));
    w.s = 4'((1 << m_acc.size()) - 1);
    exp_q.push_back(w);
    m_acc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    tx_q.push_back(b);
    m_acc.push_back(b);
    m_bc++;
    if (m_acc.size() == 4) m_emit();
  endtask

  task automatic m_flush();
    if (m_acc.size() != 0) m_emit();
  endtask

  task automatic m_reset();
    m_acc.delete();
    exp_q.delete();
    tx_q.delete();
    m_bc = 0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // uart_rx stand-in: holds a byte until acknowledged, then idles a few cycles.
  initial begin
    int gap;
    gap = 0;
    rx_data_valid = 1'b0;
    rx_data = 8'h00;
    rx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_data_valid = 1'b0;
        gap = 0;
      end else if (rx_data_valid) begin
        if (rx_ctrl[1]) begin
          rx_data_valid = 1'b0;
          gap = int'($urandom_range(0, max_gap));
        end
      end else if (gap > 0) begin
        gap--;
      end else if (tx_q.size() > 0) begin
        rx_data = tx_q.pop_front();
        rx_data_valid = 1'b1;
      end
      rx_ready = ~rx_data_valid;
    end
  end

  initial begin
    word_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode == 2) word_ready = 1'($urandom_range(0, 1));
      else word_ready = (ready_mode == 1);
    end
  end

  // Scoreboard and pulse monitors.
  initial begin
    int ack_run;
    int to_run;
    word_t e;
    ack_run = 0;
    to_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ack_run = 0;
        to_run = 0;
      end else begin
        if (rx_ctrl[1]) begin
          if (ack_run == 0) begin
            ack_cnt++;
            last_ack_cyc = cyc;
          end
          ack_run++;
        end else if (ack_run != 0) begin
          chk("ack_width", ack_run, 1);
          ack_run = 0;
        end
        if (timeout) begin
          if (to_run == 0) begin
            to_cnt++;
            last_to_cyc = cyc;
          end
          to_run++;
        end else if (to_run != 0) begin
          chk("timeout_width", to_run, 1);
          to_run = 0;
        end
        if (word_valid && word_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_word", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("word_data", word_data, e.d);
            chk("word_strb", 32'(word_strb), 32'(e.s));
          end
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_acks(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (ack_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, ack_cnt, target);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || rx_data_valid || busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_words_left"}, exp_q.size(), 0);
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0;
    int t0;
    int a_cyc;
    int lat;
    int n;
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) drive_edge();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rx_ctrl", 32'(rx_ctrl), 0);
    chk("rst_word_valid", 32'(word_valid), 0);
    chk("rst_word_data", word_data, 0);
    chk("rst_word_strb", 32'(word_strb), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_byte_count", 32'(byte_count), 0);
    chk("rst_busy", 32'(busy), 0);

    // 1: one full word
    drive_edge();
    enable = 1'b1;
    ready_mode = 1;
    @(negedge clk);
    chk("en_delay_before", 32'(rx_ctrl[0]), 0);
    @(negedge clk);
    chk("en_delay_after", 32'(rx_ctrl[0]), 1);
    a0 = ack_cnt;
    t0 = to_cnt;
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h33);
    send_byte(8'h0F);
    wait_drain(2000, "t1");
    chk("t1_acks", ack_cnt - a0, 4);
    chk("t1_timeouts", to_cnt - t0, 0);
    chk("t1_byte_count", 32'(byte_count), m_bc % 65536);

    // 2: partial word flushed by idle timeout
    a0 = ack_cnt;
    t0 = to_cnt;
    send_byte(8'h12);
    send_byte(8'h34);
    m_flush();
    wait_acks(a0 + 2, 200, "t2_acks");
    a_cyc = last_ack_cyc;
    wait_drain(TO_CYC + 200, "t2");
    lat = last_to_cyc - a_cyc;
    chk("t2_timeouts", to_cnt - t0, 1);
    chk("t2_latency_in_window", 32'(lat >= TO_CYC && lat <= TO_CYC + 10), 1);

    // 3: backpressure with word_ready low
    drive_edge();
    ready_mode = 0;
    a0 = ack_cnt;
    t0 = to_cnt;
    for (int i = 0; i < 20; i++) send_byte(8'($urandom));
    wait_acks(a0 + 19, 600, "t3_acks19");
    repeat (20) @(negedge clk);
    chk("t3_held_acks", ack_cnt - a0, 19);
    chk("t3_ack_low", 32'(rx_ctrl[1]), 0);
    chk("t3_byte_held", 32'(rx_data_valid), 1);
    chk("t3_head_valid", 32'(word_valid), 1);
    drive_edge();
    ready_mode = 1;
    wait_drain(2000, "t3");
    chk("t3_acks", ack_cnt - a0, 20);
    chk("t3_timeouts", to_cnt - t0, 0);
    chk("t3_byte_count", 32'(byte_count), m_bc % 65536);

    // 4: enable drop flushes partial word without timeout
    a0 = ack_cnt;
    t0 = to_cnt;
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    wait_acks(a0 + 3, 200, "t4_acks");
    drive_edge();
    enable = 1'b0;
    m_flush();
    @(negedge clk);
    @(negedge clk);
    chk("t4_rx_ctrl_off", 32'(rx_ctrl), 0);
    wait_drain(200, "t4");
    chk("t4_timeouts", to_cnt - t0, 0);

    // 5: reset mid-word discards partial bytes
    drive_edge();
    enable = 1'b1;
    a0 = ack_cnt;
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    wait_acks(a0 + 2, 200, "t5_pre_acks");
    drive_edge();
    rst = 1'b1;
    m_reset();
    drive_edge();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_byte_count", 32'(byte_count), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_word_valid", 32'(word_valid), 0);
    chk("t5_rst_rx_ctrl", 32'(rx_ctrl), 0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    wait_drain(2000, "t5");
    chk("t5_byte_count", 32'(byte_count), m_bc % 65536);

    // 6: full FIFO, lane-3 byte arrives together with a pop
    drive_edge();
    ready_mode = 0;
    a0 = ack_cnt;
    for (int i = 0; i < 19; i++) send_byte(8'($urandom));
    wait_acks(a0 + 19, 600, "t6_acks19");
    repeat (5) @(negedge clk);
    drive_edge();
    ready_mode = 1;
    send_byte(8'($urandom));
    wait_acks(a0 + 20, 4, "t6_no_stall");
    wait_drain(2000, "t6");
    chk("t6_byte_count", 32'(byte_count), m_bc % 65536);

    // 7: random bytes, gaps and downstream readiness
    drive_edge();
    ready_mode = 2;
    max_gap = 4;
    a0 = ack_cnt;
    t0 = to_cnt;
    n = int'($urandom_range(30, 60));
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
    m_flush();
    wait_drain(n * 30 + TO_CYC + 500, "t7");
    chk("t7_acks", ack_cnt - a0, n);
    chk("t7_timeouts", to_cnt - t0, ((n % 4) != 0) ? 1 : 0);
    chk("t7_byte_count", 32'(byte_count), m_bc % 65536);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for uart_rx. It enables the receiver and acknowledges each byte it delivers. Bytes are packed little-endian into 32-bit words, buffered in a small word FIFO and handed to a downstream memory writer (bootloader/program loader) over a valid/ready handshake. An idle-line timeout flushes partial words.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BODE_RATE, 115_200, UART bit rate in bit/s; must match the uart_rx instance
TIMEOUT_CHARS, 4, idle character times before a partial word is flushed
FIFO_DEPTH, 4, word FIFO entries; power of two, at least 2

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
enable  input  1  receive enable from the CSR
rx_data_valid  input  1  uart_rx has a byte held; stays high until acknowledged
rx_data  input  8  byte from uart_rx; stable while rx_data_valid is high
rx_ready  input  1  uart_rx idle/ready; status only, not used for sequencing
rx_ctrl  output  2  to uart_rx; bit0 = receiver enable, bit1 = byte acknowledge (single-cycle pulse)
word_valid  output  1  FIFO head is valid
word_data  output  32  FIFO head data; first byte in [7:0]
word_strb  output  4  valid byte lanes of word_data
word_ready  input  1  downstream accepts the head word
timeout  output  1  one-cycle pulse when a partial word is flushed by timeout
byte_count  output  16  accepted bytes since reset, wraps modulo 2^16
busy  output  1  high when byte_idx != 0 or FIFO not empty

Behaviour:
- One clock, synchronous active-high reset. Reset values: rx_ctrl=00, word_valid=0, word_data=0, word_strb=0, timeout=0, byte_count=0, busy=0, byte_idx=0, FIFO empty, state=IDLE.
- TIMEOUT_CYCLES = TIMEOUT_CHARS*10*CLK_FREQ/BODE_RATE, integer division.
- rx_ctrl[0] is registered: equals enable delayed by one cycle.
- States:
  - IDLE: rx_ctrl[0]=0. Go to ARMED when enable=1.
  - ARMED: wait for a byte. On rx_data_valid=1 with capture allowed: write rx_data into lane byte_idx, increment byte_count, clear the timeout counter, and assert rx_ctrl[1] for exactly the next cycle. Then go to WAIT_CLR.
  - WAIT_CLR: hold until rx_data_valid=0, then return to ARMED. This prevents double capture.
  - FLUSH: push the partial word, then go to IDLE if enable=0, else ARMED.
- Capture allowed: byte_idx<3, or byte_idx==3 and the FIFO can accept a push.
  - If capture is not allowed, the byte stays unacknowledged and rx_ctrl[1] stays 0 (backpressure). Overrun inside uart_rx is out of scope.
- Word completion: capturing lane 3 pushes {lanes} with strb=1111 in the same cycle and sets byte_idx=0.
- Timeout: counter runs in ARMED while byte_idx!=0.
  - At TIMEOUT_CYCLES-1: enter FLUSH and push with strb=(1<<byte_idx)-1. Unused lanes read 0.
  - timeout pulses for 1 cycle on that push.
  - If the FIFO is full, remain in FLUSH until a push is possible.
- enable falls while byte_idx!=0: enter FLUSH, push the partial word without a timeout pulse, then go to IDLE.
  - enable falls while byte_idx=0: go straight to IDLE.
  - A byte already captured is always acknowledged, even if enable falls that cycle.
- FIFO:
  - Push is possible when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop happens in the same cycle.
  - Pop on word_valid&&word_ready.
  - word_* outputs are the registered head. First-word latency: word_valid rises the cycle after the push.
  - Order is strictly preserved.
- busy is combinational from byte_idx and the FIFO count.
- rst mid-operation discards partial bytes and all FIFO contents. No pending acknowledge is issued after reset.

Test Plan:
Bench setting: CLK_FREQ=100_000_000, BODE_RATE=10_000_000, TIMEOUT_CHARS=4 (TIMEOUT_CYCLES=400), FIFO_DEPTH=4.
1. enable=1, word_ready=1, send 0x55,0xAA,0x33,0x0F -> one word 0x0F33AA55, strb=1111; byte_count=4; exactly four single-cycle rx_ctrl[1] pulses; timeout never asserted.
2. Send 0x12,0x34, then line idle -> 400 cycles after the second capture: word 0x00003412, strb=0011, one-cycle timeout pulse.
3. word_ready=0, send 20 bytes -> 16 bytes buffered (4 words); 17th byte captured into lane 0 of the next word; 20th byte left unacknowledged with rx_ctrl[1] low. Then word_ready=1 -> words drain in order, the held byte is acknowledged, and a fifth word completes; byte_count=20.
4. Send 0xA1,0xB2,0xC3, then deassert enable -> word 0x00C3B2A1, strb=0111; no timeout pulse; rx_ctrl=00 within 2 cycles.
5. Send 2 bytes, pulse rst for 1 cycle, then send 0x01,0x02,0x03,0x04 -> only word 0x04030201 appears; byte_count=4.
6. FIFO full with byte_idx=3 and word_ready=1 when the 4th byte arrives -> push and pop in the same cycle; no stall; count stays 4; output order correct.
